hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage RV64I core; sits beside the EX-stage
//  forwarding logic and covers the hazards forwarding cannot resolve. It detects load-use
//  interlocks, EX-stage control redirects and multi-cycle data-memory waits. From these it
//  drives per-stage stall/flush strobes into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  It also keeps saturating stall/flush perf counters and a data-memory timeout watchdog.
// PARAMETERS
//  CNT_W        32   width of perf counters stall_cnt / flush_cnt
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before mem_err; must be >=1, < 2**16
// PORTS
//  clk           in   1   core clock
//  rst_n         in   1   synchronous, active-low reset
//  id_rs1_en     in   1   instr in ID reads rs1
//  id_rs2_en     in   1   instr in ID reads rs2
//  id_rs1        in   5   rs1 index of instr in ID
//  id_rs2        in   5   rs2 index of instr in ID
//  ex_mem_read   in   1   instr in ID/EX is a load
//  ex_reg_wen    in   1   instr in ID/EX writes rd
//  ex_rd         in   5   rd index of instr in ID/EX
//  ex_redirect   in   1   branch taken / jal / jalr resolved in EX this cycle
//  mem_req       in   1   EX/MEM holds a load/store accessing data memory
//  mem_ack       in   1   data memory completes the access this cycle
//  pc_stall      out  1   hold PC
//  ifid_stall    out  1   hold IF/ID
//  ifid_flush    out  1   load bubble into IF/ID
//  idex_stall    out  1   hold ID/EX
//  idex_flush    out  1   load bubble into ID/EX
//  exmem_stall   out  1   hold EX/MEM
//  memwb_flush   out  1   load bubble into MEM/WB
//  mem_err       out  1   sticky: data-memory timeout occurred
//  stall_cnt     out  CNT_W  cycles with pc_stall=1 (saturating)
//  flush_cnt     out  CNT_W  cycles with ifid_flush|idex_flush=1 (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN, wait counter=0, mem_err=0, stall_cnt=flush_cnt=0.
//   While rst_n=0 all strobe outputs are forced 0.
//  Hazard terms, combinational, same cycle:
//   memw = mem_req & ~mem_ack
//   lu   = ex_mem_read & ex_reg_wen & ex_rd!=0 &
//          ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd))   (x0 never interlocks)
//  Priority per cycle (only the highest applies):
//   1. state ERR: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush = 1.
//   2. memw (RUN or MEM_WAIT): same five strobes = 1. ex_redirect and lu are ignored; ID/EX
//      is frozen, so both are re-evaluated in the cycle mem_ack arrives.
//   3. ex_redirect: ifid_flush=1, idex_flush=1, no stalls. A simultaneous lu is squashed
//      (its ID instr is on the wrong path).
//   4. lu: pc_stall=1, ifid_stall=1, idex_flush=1; one bubble per occurrence. The next
//      cycle the load is in EX/MEM and forwarding resolves the dependency.
//   5. else all strobes 0.
//  Zero-wait memory (mem_req & mem_ack in the same cycle) causes no stall.
//  FSM (registered):
//   RUN      -> MEM_WAIT when memw; wait counter := 1.
//   MEM_WAIT -> RUN when mem_ack. Otherwise counter++.
//   MEM_WAIT -> ERR when counter==MEM_TIMEOUT & ~mem_ack; mem_err := 1.
//   ERR      -> stays in ERR until reset; mem_ack is ignored. mem_err stays 1.
//   A mem_ack in the same cycle the counter hits MEM_TIMEOUT wins: go to RUN, no error.
//  Counters: +1 per qualifying cycle, hold at 2**CNT_W-1. ERR cycles count as stall cycles.
//  Reset asserted mid-MEM_WAIT/ERR: next cycle is RUN with all strobes 0; no pending
//   hazard survives reset.
// TESTING
//  T1 load x5 in EX, ID add reads x5 (rs1_en=1) -> 1 cycle pc_stall=ifid_stall=idex_flush=1;
//     stall_cnt=1, flush_cnt=1.
//  T2 same as T1 but ex_rd=0, or rs1==5 with id_rs1_en=0 -> no strobes.
//  T3 ex_redirect=1 with lu=1 in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0.
//  T4 mem_req=1, mem_ack=0 for 3 cycles then 1 -> 3 cycles of pc/ifid/idex/exmem stall +
//     memwb_flush; RUN on the 4th cycle, stall_cnt=3.
//  T5 MEM_TIMEOUT=4, mem_ack held 0 -> mem_err rises after the 4th MEM_WAIT cycle, stalls
//     stay high; mem_ack=1 has no effect; rst_n=0 for one edge -> all outputs/counters 0.
//  T6 CNT_W=4, 20 consecutive lu cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_unit_if.sv
//==============================================================================
// Module      : hazard_unit_if
// Description : Bundle of pipeline-hazard inputs and stall/flush outputs that
//               connects the 5-stage core datapath to the hazard controller.
//               master : datapath side (drives hazard inputs, reads strobes)
//               slave  : hazard controller side
// Ports       : id_rs1_en/id_rs2_en/id_rs1/id_rs2  - ID-stage source operands
//               ex_mem_read/ex_reg_wen/ex_rd        - ID/EX destination info
//               ex_redirect                         - control redirect in EX
//               mem_req/mem_ack                     - data-memory handshake
//               pc_stall .. memwb_flush             - per-stage strobes
//               mem_err, stall_cnt, flush_cnt       - status / perf counters
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic             id_rs1_en;
    logic             id_rs2_en;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_mem_read;
    logic             ex_reg_wen;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               ex_mem_read, ex_reg_wen, ex_rd, ex_redirect,
               mem_req, mem_ack,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               ex_mem_read, ex_reg_wen, ex_rd, ex_redirect,
               mem_req, mem_ack,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
//==============================================================================
// Module      : hazard_unit
// Description : Stall/flush controller for the 5-stage RV64I pipeline. Detects
//               load-use interlocks, EX-stage redirects and data-memory waits,
//               drives per-stage stall/flush strobes, keeps saturating
//               stall/flush counters and a data-memory timeout watchdog.
// Ports       : clk   - core clock
//               rst_n - synchronous active-low reset
//               hz    - hazard_unit_if.slave (hazard inputs, strobes, status)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [1:0]       c_ST_RUN  = 2'd0;
    localparam logic [1:0]       c_ST_WAIT = 2'd1;
    localparam logic [1:0]       c_ST_ERR  = 2'd2;
    localparam logic [15:0]      c_TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [15:0]      r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_memw;
    logic w_lu;
    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_idex_flush;
    logic w_exmem_stall;
    logic w_memwb_flush;

    assign w_memw = hz.mem_req & ~hz.mem_ack;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_lu = hz.ex_mem_read & hz.ex_reg_wen & (hz.ex_rd != 5'd0) &
                  ((hz.id_rs1_en & (hz.id_rs1 == hz.ex_rd)) |
                   (hz.id_rs2_en & (hz.id_rs2 == hz.ex_rd)));

    // Strict priority: ERR / memory wait freeze everything up to EX/MEM and
    // bubble MEM/WB; a redirect squashes any load-use seen on the wrong path.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_flush = 1'b0;
        if (rst_n) begin
            if ((r_state == c_ST_ERR) || w_memw) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_stall  = 1'b1;
                w_exmem_stall = 1'b1;
                w_memwb_flush = 1'b1;
            end else if (hz.ex_redirect) begin
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
            end else if (w_lu) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_flush  = 1'b1;
            end
        end
    end

    // Memory-wait watchdog. The counter holds the number of MEM_WAIT cycles
    // entered so far; an ack arriving on the timeout cycle still wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_memw) begin
                        r_state    <= c_ST_WAIT;
                        r_wait_cnt <= 16'd1;
                    end
                end
                c_ST_WAIT: begin
                    if (hz.mem_ack) begin
                        r_state    <= c_ST_RUN;
                        r_wait_cnt <= 16'd0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state    <= c_ST_ERR;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                c_ST_ERR: begin
                    r_state   <= c_ST_ERR;
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= c_ST_RUN;
                    r_wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((w_ifid_flush || w_idex_flush) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_stall    = w_pc_stall;
    assign hz.ifid_stall  = w_ifid_stall;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_stall  = w_idex_stall;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_stall = w_exmem_stall;
    assign hz.memwb_flush = w_memwb_flush;
    assign hz.mem_err     = r_mem_err;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//==============================================================================
// Module      : tb_hazard_unit
// Description : Directed self-checking bench for hazard_unit. Instance A uses
//               a 4-cycle memory timeout; instance B uses 4-bit counters to
//               exercise saturation. Both see identical hazard inputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic       id_rs1_en, id_rs2_en, ex_mem_read, ex_reg_wen;
    logic       ex_redirect, mem_req, mem_ack;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    int n_checks = 0;
    int n_errors = 0;

    hazard_unit_if #(.CNT_W(32)) if_a ();
    hazard_unit_if #(.CNT_W(4))  if_b ();

    assign if_a.id_rs1_en = id_rs1_en;   assign if_b.id_rs1_en = id_rs1_en;
    assign if_a.id_rs2_en = id_rs2_en;   assign if_b.id_rs2_en = id_rs2_en;
    assign if_a.id_rs1    = id_rs1;      assign if_b.id_rs1    = id_rs1;
    assign if_a.id_rs2    = id_rs2;      assign if_b.id_rs2    = id_rs2;
    assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.ex_reg_wen  = ex_reg_wen;  assign if_b.ex_reg_wen  = ex_reg_wen;
    assign if_a.ex_rd       = ex_rd;       assign if_b.ex_rd       = ex_rd;
    assign if_a.ex_redirect = ex_redirect; assign if_b.ex_redirect = ex_redirect;
    assign if_a.mem_req     = mem_req;     assign if_b.mem_req     = mem_req;
    assign if_a.mem_ack     = mem_ack;     assign if_b.mem_ack     = mem_ack;

    hazard_unit #(.CNT_W(32), .MEM_TIMEOUT(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_a.slave)
    );

    hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(255)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_en = 0; id_rs2_en = 0; id_rs1 = 0; id_rs2 = 0;
        ex_mem_read = 0; ex_reg_wen = 0; ex_rd = 0;
        ex_redirect = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Load writing x5 in EX, ID instruction reading x5 through rs1.
    task automatic set_lu_rs1();
        ex_mem_read = 1; ex_reg_wen = 1; ex_rd = 5'd5;
        id_rs1_en = 1; id_rs1 = 5'd5;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        set_lu_rs1();
        tick();
        tick();
        // Reset: strobes forced low even with a load-use present.
        check("rst_pc_stall",   if_a.pc_stall, 0);
        check("rst_idex_flush", if_a.idex_flush, 0);
        check("rst_stall_cnt",  if_a.stall_cnt, 0);
        check("rst_flush_cnt",  if_a.flush_cnt, 0);
        check("rst_mem_err",    if_a.mem_err, 0);

        // T1: load-use on rs1
        rst_n = 1;
        #1;
        check("t1_pc_stall",    if_a.pc_stall, 1);
        check("t1_ifid_stall",  if_a.ifid_stall, 1);
        check("t1_idex_flush",  if_a.idex_flush, 1);
        check("t1_ifid_flush",  if_a.ifid_flush, 0);
        check("t1_exmem_stall", if_a.exmem_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("t1_stall_cnt", if_a.stall_cnt, 1);
        check("t1_flush_cnt", if_a.flush_cnt, 1);
        check("t1_one_bubble", if_a.pc_stall, 0);

        // Load-use through rs2
        ex_mem_read = 1; ex_reg_wen = 1; ex_rd = 5'd5;
        id_rs2_en = 1; id_rs2 = 5'd5;
        #1;
        check("lu_rs2_pc_stall", if_a.pc_stall, 1);
        tick();
        clear_inputs();

        // T2: no interlock cases
        ex_mem_read = 1; ex_reg_wen = 1; ex_rd = 5'd0; id_rs1_en = 1; id_rs1 = 5'd0;
        #1;
        check("t2_x0_pc_stall",   if_a.pc_stall, 0);
        check("t2_x0_idex_flush", if_a.idex_flush, 0);
        tick();
        clear_inputs();
        set_lu_rs1(); id_rs1_en = 0;
        #1;
        check("t2_rs1dis_pc_stall", if_a.pc_stall, 0);
        tick();
        clear_inputs();
        set_lu_rs1(); ex_reg_wen = 0;
        #1;
        check("t2_nowen_pc_stall", if_a.pc_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("t2_stall_cnt", if_a.stall_cnt, 2);
        check("t2_flush_cnt", if_a.flush_cnt, 2);

        // T3: redirect squashes simultaneous load-use
        set_lu_rs1(); ex_redirect = 1;
        #1;
        check("t3_ifid_flush", if_a.ifid_flush, 1);
        check("t3_idex_flush", if_a.idex_flush, 1);
        check("t3_pc_stall",   if_a.pc_stall, 0);
        check("t3_ifid_stall", if_a.ifid_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("t3_flush_cnt", if_a.flush_cnt, 3);
        check("t3_stall_cnt", if_a.stall_cnt, 2);

        // T4: 3 wait cycles, redirect ignored while waiting
        mem_req = 1; mem_ack = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_pc_stall",    if_a.pc_stall, 1);
            check("t4_idex_stall",  if_a.idex_stall, 1);
            check("t4_exmem_stall", if_a.exmem_stall, 1);
            check("t4_memwb_flush", if_a.memwb_flush, 1);
            check("t4_ifid_flush",  if_a.ifid_flush, 0);
            tick();
        end
        mem_ack = 1;
        #1;
        check("t4_ack_pc_stall",   if_a.pc_stall, 0);
        check("t4_ack_exmem",      if_a.exmem_stall, 0);
        check("t4_ack_redirect",   if_a.ifid_flush, 1);
        tick();
        clear_inputs();
        #1;
        check("t4_stall_cnt", if_a.stall_cnt, 5);
        check("t4_flush_cnt", if_a.flush_cnt, 4);
        check("t4_run_pc_stall", if_a.pc_stall, 0);

        // Zero-wait access
        mem_req = 1; mem_ack = 1;
        #1;
        check("zw_pc_stall", if_a.pc_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("zw_run_pc_stall", if_a.pc_stall, 0);

        // Ack on the timeout cycle wins
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 4; i++) tick();
        mem_ack = 1;
        #1;
        check("tmo_ack_pc_stall", if_a.pc_stall, 0);
        tick();
        clear_inputs();
        #1;
        check("tmo_ack_mem_err",  if_a.mem_err, 0);
        check("tmo_ack_run",      if_a.pc_stall, 0);
        check("tmo_ack_stall_cnt", if_a.stall_cnt, 9);

        // T5: timeout -> ERR
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_pre_mem_err", if_a.mem_err, 0);
        tick();
        check("t5_mem_err", if_a.mem_err, 1);
        mem_req = 0; mem_ack = 1;
        #1;
        check("t5_err_pc_stall",    if_a.pc_stall, 1);
        check("t5_err_memwb_flush", if_a.memwb_flush, 1);
        tick();
        check("t5_err_sticky",    if_a.mem_err, 1);
        check("t5_err_still_stall", if_a.exmem_stall, 1);
        check("t5_stall_cnt",     if_a.stall_cnt, 15);
        rst_n = 0;
        #1;
        check("t5_rst_pc_stall", if_a.pc_stall, 0);
        tick();
        rst_n = 1;
        clear_inputs();
        #1;
        check("t5_post_mem_err",   if_a.mem_err, 0);
        check("t5_post_stall_cnt", if_a.stall_cnt, 0);
        check("t5_post_flush_cnt", if_a.flush_cnt, 0);
        check("t5_post_pc_stall",  if_a.pc_stall, 0);
        check("t5_post_exmem",     if_a.exmem_stall, 0);

        // T6: saturation on 4-bit counters
        set_lu_rs1();
        for (int i = 0; i < 15; i++) tick();
        check("t6_b_stall_15", if_b.stall_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        #1;
        check("t6_b_stall_sat", if_b.stall_cnt, 15);
        check("t6_b_flush_sat", if_b.flush_cnt, 15);
        check("t6_a_stall_cnt", if_a.stall_cnt, 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
